pfd_charge_pump: RTL

PFD_CHARGE_PUMP -- requirements
Module: pfd_charge_pump

---
 rtl/pfd_charge_pump.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/pfd_charge_pump.sv
// pfd_charge_pump: phase-frequency detector with charge-pump current output.
//
// Compares one-cycle reference and feedback edge pulses, drives up/dn
// enables and a signed charge-pump current, measures the phase error in
// clock cycles and raises a lock indicator after a run of small errors.
//
// Ports:
//   clk                 in   single clock, all state changes on posedge
//   reset               in   synchronous active-high reset
//   ref_edge            in   one-cycle pulse on a reference-clock edge
//   fb_edge             in   one-cycle pulse on a divided-VCO edge
//   output_current_real out  signed 19-bit pump current (loop filter input)
//   up / dn             out  charge-pump source / sink enables
//   phase_err           out  signed cycle count of last comparison (+ = ref leads)
//   phase_valid         out  one-cycle pulse when phase_err updates
//   lock                out  lock indicator
module pfd_charge_pump #(
  parameter int unsigned I_UP       = 1000,
  parameter int unsigned I_DN       = 1000,
  parameter int unsigned DEADZONE   = 2,
  parameter int unsigned LOCK_WIDTH = 4,
  parameter int unsigned LOCK_COUNT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ref_edge,
  input  logic               fb_edge,
  output logic signed [18:0] output_current_real,
  output logic               up,
  output logic               dn,
  output logic signed [15:0] phase_err,
  output logic               phase_valid,
  output logic               lock
);

  localparam logic [18:0] I_UP_C   = 19'(I_UP);
  localparam logic [18:0] I_DN_C   = 19'(I_DN);
  localparam logic [3:0]  DZ_C     = 4'(DEADZONE);
  localparam logic [15:0] LWIDTH_C = 16'(LOCK_WIDTH);
  localparam logic [7:0]  LCOUNT_C = 8'(LOCK_COUNT);

  typedef enum logic [1:0] {S_IDLE, S_UP, S_DN, S_RST} state_e;

  state_e             state_q, state_d;
  logic [14:0]        width_q, width_d;
  logic [3:0]         rst_cnt_q, rst_cnt_d;
  logic               pend_ref_q, pend_ref_d;
  logic               pend_fb_q, pend_fb_d;
  logic signed [15:0] phase_err_q, phase_err_d;
  logic               phase_valid_q, phase_valid_d;
  logic [7:0]         lock_cnt_q, lock_cnt_d;
  logic               lock_q, lock_d;

  logic [14:0]        width_inc_s;
  logic               pr_s, pf_s;
  logic [15:0]        abs_err_s;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      width_q       <= 15'd0;
      rst_cnt_q     <= 4'd0;
      pend_ref_q    <= 1'b0;
      pend_fb_q     <= 1'b0;
      phase_err_q   <= 16'sd0;
      phase_valid_q <= 1'b0;
      lock_cnt_q    <= 8'd0;
      lock_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      width_q       <= width_d;
      rst_cnt_q     <= rst_cnt_d;
      pend_ref_q    <= pend_ref_d;
      pend_fb_q     <= pend_fb_d;
      phase_err_q   <= phase_err_d;
      phase_valid_q <= phase_valid_d;
      lock_cnt_q    <= lock_cnt_d;
      lock_q        <= lock_d;
    end
  end

  // Width counter saturates instead of wrapping for very large phase errors.
  assign width_inc_s = (width_q == 15'h7FFF) ? width_q : (width_q + 15'd1);
  // Edges arriving on the final RST cycle still count as pending.
  assign pr_s = pend_ref_q | ref_edge;
  assign pf_s = pend_fb_q  | fb_edge;

  // Next-state logic for the detector FSM, width counter and pending flags.
  always_comb begin
    state_d       = state_q;
    width_d       = width_q;
    rst_cnt_d     = rst_cnt_q;
    pend_ref_d    = pend_ref_q;
    pend_fb_d     = pend_fb_q;
    phase_err_d   = phase_err_q;
    phase_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ref_edge && fb_edge) begin
          phase_err_d   = 16'sd0;
          phase_valid_d = 1'b1;
        end else if (ref_edge) begin
          state_d = S_UP;
          width_d = 15'd1;
        end else if (fb_edge) begin
          state_d = S_DN;
          width_d = 15'd1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_UP: begin
        if (fb_edge) begin
          state_d       = S_RST;
          rst_cnt_d     = DZ_C;
          phase_err_d   = $signed({1'b0, width_q});
          phase_valid_d = 1'b1;
        end else begin
          width_d = width_inc_s;
        end
      end
      S_DN: begin
        if (ref_edge) begin
          state_d       = S_RST;
          rst_cnt_d     = DZ_C;
          phase_err_d   = -$signed({1'b0, width_q});
          phase_valid_d = 1'b1;
        end else begin
          width_d = width_inc_s;
        end
      end
      S_RST: begin
        if (rst_cnt_q <= 4'd1) begin
          pend_ref_d = 1'b0;
          pend_fb_d  = 1'b0;
          rst_cnt_d  = 4'd0;
          if (pr_s && !pf_s) begin
            state_d = S_UP;
            width_d = 15'd1;
          end else if (pf_s && !pr_s) begin
            state_d = S_DN;
            width_d = 15'd1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          rst_cnt_d  = rst_cnt_q - 4'd1;
          pend_ref_d = pr_s;
          pend_fb_d  = pf_s;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign abs_err_s = phase_err_q[15] ? (16'd0 - phase_err_q) : phase_err_q;

  // Lock counter evaluates the comparison one cycle after phase_valid.
  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (phase_valid_q) begin
      if (abs_err_s <= LWIDTH_C) begin
        lock_cnt_d = (lock_cnt_q >= LCOUNT_C) ? LCOUNT_C : (lock_cnt_q + 8'd1);
      end else begin
        lock_cnt_d = 8'd0;
      end
    end else begin
      lock_cnt_d = lock_cnt_q;
    end
    lock_d = (lock_cnt_d == LCOUNT_C);
  end

  assign up                  = (state_q == S_UP) || (state_q == S_RST);
  assign dn                  = (state_q == S_DN) || (state_q == S_RST);
  assign output_current_real = $signed(up ? I_UP_C : 19'd0) - $signed(dn ? I_DN_C : 19'd0);
  assign phase_err           = phase_err_q;
  assign phase_valid         = phase_valid_q;
  assign lock                = lock_q;

endmodule
